ps2_key_decoder: RTL and testbench
==================================

// Module: ps2_key_decoder
// PURPOSE
//  Sequences the byte stream from ps2_receiver into keyboard key events (scan code set 2).
//  Folds E0 (extended) and F0 (break) prefixes, collapses the 8-byte Pause sequence and
//  discards keyboard status bytes. Buffers events in a small FIFO toward the CPU keyboard
//  register logic.
// PARAMETERS
//  FIFO_DEPTH      8       event FIFO entries; must be a power of 2, >= 2
//  TIMEOUT_CYCLES  24000   idle clk cycles in a prefix state before abandoning it (2 ms @ 12 MHz)
//  TIMEOUT_W       16      width of timeout counter; 2**TIMEOUT_W > TIMEOUT_CYCLES
// PORTS
//  clk         in   1    system clock
//  rst_n       in   1    asynchronous reset, active low
//  rx_data     in   8    ps2_receiver out; valid while rx_ready high
//  rx_ready    in   1    ps2_receiver ready (level; rises once per received byte)
//  ev_valid    out  1    FIFO head holds an event
//  ev_code     out  8    head event: final scan code byte
//  ev_ext      out  1    head event: E0 prefix seen (or Pause)
//  ev_break    out  1    head event: key release (F0 seen)
//  ev_ready    in   1    consumer pops head when ev_valid & ev_ready at posedge clk
//  fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries
//  overflow    out  1    sticky: event dropped because FIFO full
//  ovf_clr     in   1    clears overflow on posedge clk (set wins if same cycle)
// BEHAVIOUR
//  Reset (rst_n=0, async): FIFO empty, ev_valid=0, fifo_count=0, overflow=0, FSM=IDLE,
//   timeout counter=0, rdy_q=1 (a rx_ready already high at reset release is NOT a new byte).
//  Byte strobe: stb = rx_ready & ~rdy_q; rdy_q <= rx_ready every clk. One stb per rising edge.
//  FSM acts on stb at the same posedge; a resulting event is written to the FIFO at that edge;
//   ev_valid is high in the following cycle (latency 1 clk from rx_ready rise). No bypass.
//  States / transitions on stb with byte b:
//   IDLE:   E0->EXT; F0->BRK; E1->PAUSE (skip=7); FA,AA,EE,FE,FC,00,FF->IDLE, no event;
//           else emit {b,ext=0,brk=0}, stay IDLE.
//   EXT:    F0->EXTBRK; E0->EXT (repeat prefix ignored); 12->IDLE, no event (fake shift);
//           else emit {b,1,0} ->IDLE.
//   BRK:    emit {b,0,1} ->IDLE (any b, including E0/F0 values).
//   EXTBRK: 12->IDLE, no event; else emit {b,1,1} ->IDLE.
//   PAUSE:  skip <= skip-1 per byte, content ignored; when skip==1 on stb emit {E1,1,0} ->IDLE.
//  Timeout: in any non-IDLE state, counter +1 per clk without stb, cleared on every stb and in
//   IDLE; reaching TIMEOUT_CYCLES-1 forces IDLE next edge, no event, counter cleared.
//  FIFO: show-ahead; ev_* reflect head combinationally from storage; pointers wrap mod DEPTH.
//   Push & pop same edge: both happen, count unchanged (also when full: push accepted).
//   Push when full without pop: event dropped, overflow <= 1, FIFO contents untouched.
//   Pop when empty: ignored. ev_code/ev_ext/ev_break undefined-but-stable when ev_valid=0.
//  stb and timeout expiry on same edge: stb wins (counter clears, byte processed).
//  Reset mid-sequence or with FIFO non-empty: everything discarded, no partial event.
// TESTING
//  1 Bytes 1C (ready pulses, ev_ready=1) -> one event {1C,0,0}; then F0,1C -> {1C,0,1}.
//  2 E0,75 -> {75,1,0}; E0,F0,75 -> {75,1,1}; E0,12 / E0,F0,12 -> no events.
//  3 E1,14,77,E1,F0,14,F0,77 -> exactly one {E1,1,0}; FA and AA alone -> no events.
//  4 ev_ready=0, send 9 makes with DEPTH=8 -> fifo_count=8, overflow=1, pop order = first 8;
//    ovf_clr -> overflow=0; push+pop while full keeps count=8, order intact.
//  5 F0 then silence TIMEOUT_CYCLES clk, then 1C -> {1C,0,0} (break abandoned).
//  6 rst_n low after E0 with 3 queued events and rx_ready held high -> count=0, no event
//    until rx_ready falls and rises again; next 5A -> {5A,0,0}.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// PS/2 scan code set 2 byte sequencer: folds E0/F0 prefixes, collapses Pause,
// drops status bytes and queues key events in a show-ahead FIFO.
module ps2_key_decoder #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 24000,
    parameter int TIMEOUT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_ready,
    output logic                          ev_valid,
    output logic [7:0]                    ev_code,
    output logic                          ev_ext,
    output logic                          ev_break,
    input  logic                          ev_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          ovf_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXTBRK,
        S_PAUSE
    } state_t;

    state_t                 state, state_nx;
    logic [2:0]             skip, skip_nx;
    logic [TIMEOUT_W-1:0]   tmo, tmo_nx;
    logic                   rdy_q;
    logic                   stb;

    logic                   push;
    logic [7:0]             push_code;
    logic                   push_ext;
    logic                   push_brk;

    logic [9:0]             mem [FIFO_DEPTH];
    logic [AW-1:0]          rd_ptr;
    logic [AW-1:0]          wr_ptr;
    logic [CW-1:0]          count;
    logic                   pop;
    logic                   full;
    logic                   wr_ok;

    function automatic logic is_status(input logic [7:0] b);
        return (b == 8'hFA) || (b == 8'hAA) || (b == 8'hEE) ||
               (b == 8'hFE) || (b == 8'hFC) || (b == 8'h00) ||
               (b == 8'hFF);
    endfunction

    assign stb = rx_ready & ~rdy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            skip  <= '0;
            tmo   <= '0;
            rdy_q <= 1'b1;
        end else begin
            state <= state_nx;
            skip  <= skip_nx;
            tmo   <= tmo_nx;
            rdy_q <= rx_ready;
        end
    end

    always_comb begin
        state_nx  = state;
        skip_nx   = skip;
        tmo_nx    = '0;
        push      = 1'b0;
        push_code = rx_data;
        push_ext  = 1'b0;
        push_brk  = 1'b0;
        if (stb) begin
            unique case (state)
                S_IDLE: begin
                    if (rx_data == 8'hE0) begin
                        state_nx = S_EXT;
                    end else if (rx_data == 8'hF0) begin
                        state_nx = S_BRK;
                    end else if (rx_data == 8'hE1) begin
                        state_nx = S_PAUSE;
                        skip_nx  = 3'd7;
                    end else if (!is_status(rx_data)) begin
                        push = 1'b1;
                    end
                end
                S_EXT: begin
                    if (rx_data == 8'hF0) begin
                        state_nx = S_EXTBRK;
                    end else if (rx_data == 8'h12) begin
                        state_nx = S_IDLE;
                    end else if (rx_data != 8'hE0) begin
                        push     = 1'b1;
                        push_ext = 1'b1;
                        state_nx = S_IDLE;
                    end
                end
                S_BRK: begin
                    push     = 1'b1;
                    push_brk = 1'b1;
                    state_nx = S_IDLE;
                end
                S_EXTBRK: begin
                    push     = (rx_data != 8'h12);
                    push_ext = 1'b1;
                    push_brk = 1'b1;
                    state_nx = S_IDLE;
                end
                S_PAUSE: begin
                    // Pause carries no break code; report it as one extended make
                    if (skip == 3'd1) begin
                        push      = 1'b1;
                        push_code = 8'hE1;
                        push_ext  = 1'b1;
                        state_nx  = S_IDLE;
                    end
                    skip_nx = skip - 3'd1;
                end
                default: state_nx = S_IDLE;
            endcase
        end else if (state != S_IDLE) begin
            if (tmo == TMO_LAST) begin
                state_nx = S_IDLE;
            end else begin
                tmo_nx = tmo + 1'b1;
            end
        end
    end

    assign full     = (count == FULL_CNT);
    assign ev_valid = (count != '0);
    assign pop      = ev_valid & ev_ready;
    assign wr_ok    = push & (~full | pop);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= {push_code, push_ext, push_brk};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_ok && !pop) begin
                count <= count + 1'b1;
            end else if (!wr_ok && pop) begin
                count <= count - 1'b1;
            end
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    assign {ev_code, ev_ext, ev_break} = mem[rd_ptr];
    assign fifo_count = count;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed vector table, corner sequences and
// a random byte stream checked against a prefix-flag reference model.
module tb_ps2_key_decoder;

    localparam int DEPTH = 8;
    localparam int TMO   = 40;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        ev_valid;
    logic [7:0]  ev_code;
    logic        ev_ext;
    logic        ev_break;
    logic        ev_ready;
    logic [3:0]  fifo_count;
    logic        overflow;
    logic        ovf_clr;

    int checks = 0;
    int errors = 0;

    logic [9:0] got_q[$];
    logic [9:0] exp_q[$];

    logic m_ext;
    logic m_brk;
    int   m_pause;

    ps2_key_decoder #(
        .FIFO_DEPTH(DEPTH),
        .TIMEOUT_CYCLES(TMO),
        .TIMEOUT_W(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx_data(rx_data),
        .rx_ready(rx_ready),
        .ev_valid(ev_valid),
        .ev_code(ev_code),
        .ev_ext(ev_ext),
        .ev_break(ev_break),
        .ev_ready(ev_ready),
        .fifo_count(fifo_count),
        .overflow(overflow),
        .ovf_clr(ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every accepted pop is recorded in order
    always @(negedge clk) begin
        if (rst_n && ev_valid && ev_ready)
            got_q.push_back({ev_code, ev_ext, ev_break});
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        wait_cyc(1);
        rx_data  = b;
        rx_ready = 1'b1;
        wait_cyc(2);
        rx_ready = 1'b0;
        wait_cyc(1 + gap);
    endtask

    function automatic logic status_byte(input logic [7:0] b);
        return b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF};
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        if (m_pause > 0) begin
            m_pause--;
            if (m_pause == 0) exp_q.push_back({8'hE1, 1'b1, 1'b0});
        end else if (m_brk) begin
            if (!(m_ext && b == 8'h12)) exp_q.push_back({b, m_ext, 1'b1});
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (m_ext) begin
            if (b == 8'hF0) m_brk = 1'b1;
            else if (b == 8'h12) m_ext = 1'b0;
            else if (b != 8'hE0) begin
                exp_q.push_back({b, 1'b1, 1'b0});
                m_ext = 1'b0;
            end
        end else begin
            if (b == 8'hE0) m_ext = 1'b1;
            else if (b == 8'hF0) m_brk = 1'b1;
            else if (b == 8'hE1) m_pause = 7;
            else if (!status_byte(b)) exp_q.push_back({b, 1'b0, 1'b0});
        end
    endfunction

    typedef struct {
        logic [7:0] bytes [8];
        int         n;
        int         exp_n;
        logic [9:0] exp_ev;
    } vec_t;

    vec_t vecs [12];

    initial begin
        vecs[0]  = '{'{8'h1C,0,0,0,0,0,0,0}, 1, 1, {8'h1C,2'b00}};
        vecs[1]  = '{'{8'hF0,8'h1C,0,0,0,0,0,0}, 2, 1, {8'h1C,2'b01}};
        vecs[2]  = '{'{8'hE0,8'h75,0,0,0,0,0,0}, 2, 1, {8'h75,2'b10}};
        vecs[3]  = '{'{8'hE0,8'hF0,8'h75,0,0,0,0,0}, 3, 1, {8'h75,2'b11}};
        vecs[4]  = '{'{8'hE0,8'h12,0,0,0,0,0,0}, 2, 0, 10'h0};
        vecs[5]  = '{'{8'hE0,8'hF0,8'h12,0,0,0,0,0}, 3, 0, 10'h0};
        vecs[6]  = '{'{8'hE1,8'h14,8'h77,8'hE1,8'hF0,8'h14,8'hF0,8'h77},
                     8, 1, {8'hE1,2'b10}};
        vecs[7]  = '{'{8'hFA,0,0,0,0,0,0,0}, 1, 0, 10'h0};
        vecs[8]  = '{'{8'hAA,0,0,0,0,0,0,0}, 1, 0, 10'h0};
        vecs[9]  = '{'{8'hE0,8'hE0,8'h6B,0,0,0,0,0}, 3, 1, {8'h6B,2'b10}};
        vecs[10] = '{'{8'hF0,8'hE0,0,0,0,0,0,0}, 2, 1, {8'hE0,2'b01}};
        vecs[11] = '{'{8'hF0,8'hF0,0,0,0,0,0,0}, 2, 1, {8'hF0,2'b01}};

        rst_n    = 1'b0;
        rx_data  = 8'h1C;
        rx_ready = 1'b1;
        ev_ready = 1'b1;
        ovf_clr  = 1'b0;
        wait_cyc(3);
        chk("rst_valid", 32'(ev_valid), 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_ovf", 32'(overflow), 0);
        rst_n = 1'b1;
        wait_cyc(4);
        chk("ready_high_at_release", 32'(got_q.size()), 0);
        rx_ready = 1'b0;
        wait_cyc(2);

        for (int v = 0; v < 12; v++) begin
            got_q.delete();
            for (int j = 0; j < vecs[v].n; j++)
                send_byte(vecs[v].bytes[j], 0);
            wait_cyc(6);
            chk($sformatf("vec%0d_nev", v), 32'(got_q.size()),
                32'(vecs[v].exp_n));
            if (vecs[v].exp_n == 1 && got_q.size() > 0)
                chk($sformatf("vec%0d_ev", v), 32'(got_q[0]),
                    32'(vecs[v].exp_ev));
        end

        // Overflow, sticky flag and push+pop while full
        ev_ready = 1'b0;
        got_q.delete();
        for (int i = 0; i < 9; i++) send_byte(8'h10 + 8'(i), 0);
        wait_cyc(2);
        chk("full_count", 32'(fifo_count), DEPTH);
        chk("ovf_set", 32'(overflow), 1);
        chk("full_head", 32'(ev_code), 32'h10);
        ovf_clr = 1'b1;
        wait_cyc(1);
        ovf_clr = 1'b0;
        chk("ovf_clr", 32'(overflow), 0);
        rx_data  = 8'h20;
        rx_ready = 1'b1;
        ev_ready = 1'b1;
        wait_cyc(1);
        ev_ready = 1'b0;
        chk("pushpop_count", 32'(fifo_count), DEPTH);
        chk("pushpop_ovf", 32'(overflow), 0);
        rx_ready = 1'b0;
        wait_cyc(2);
        ev_ready = 1'b1;
        wait_cyc(14);
        chk("drain_n", 32'(got_q.size()), 9);
        for (int i = 0; i < 9 && i < got_q.size(); i++)
            chk($sformatf("drain%0d", i), 32'(got_q[i]),
                32'({(i < 8) ? 8'h10 + 8'(i) : 8'h20, 2'b00}));
        chk("drain_count", 32'(fifo_count), 0);

        // Prefix timeout: short silence keeps break, long silence drops it
        got_q.delete();
        send_byte(8'hF0, 0);
        wait_cyc(TMO / 2);
        send_byte(8'h1C, 0);
        wait_cyc(4);
        chk("short_gap_n", 32'(got_q.size()), 1);
        if (got_q.size() > 0) chk("short_gap_ev", 32'(got_q[0]), {8'h1C, 2'b01});
        got_q.delete();
        send_byte(8'hF0, 0);
        wait_cyc(TMO + 5);
        send_byte(8'h1C, 0);
        wait_cyc(4);
        chk("timeout_n", 32'(got_q.size()), 1);
        if (got_q.size() > 0) chk("timeout_ev", 32'(got_q[0]), {8'h1C, 2'b00});

        // Reset mid-sequence with queued events and rx_ready held high
        ev_ready = 1'b0;
        send_byte(8'h31, 0);
        send_byte(8'h32, 0);
        send_byte(8'h33, 0);
        send_byte(8'hE0, 0);
        chk("pre_rst_count", 32'(fifo_count), 3);
        wait_cyc(1);
        rx_data  = 8'h29;
        rx_ready = 1'b1;
        #2 rst_n = 1'b0;
        wait_cyc(3);
        rst_n = 1'b1;
        chk("midrst_count", 32'(fifo_count), 0);
        chk("midrst_valid", 32'(ev_valid), 0);
        ev_ready = 1'b1;
        got_q.delete();
        wait_cyc(5);
        chk("held_ready_nev", 32'(got_q.size()), 0);
        rx_ready = 1'b0;
        wait_cyc(2);
        send_byte(8'h5A, 0);
        wait_cyc(4);
        chk("post_rst_n", 32'(got_q.size()), 1);
        if (got_q.size() > 0) chk("post_rst_ev", 32'(got_q[0]), {8'h5A, 2'b00});

        // Random stream against the reference model
        got_q.delete();
        exp_q.delete();
        m_ext   = 1'b0;
        m_brk   = 1'b0;
        m_pause = 0;
        for (int k = 0; k < 300; k++) begin
            logic [7:0] b;
            case ($urandom_range(0, 11))
                0, 1:    b = 8'hE0;
                2, 3:    b = 8'hF0;
                4:       b = 8'hE1;
                5:       b = 8'h12;
                6:       b = 8'hFA;
                7:       b = 8'hAA;
                default: b = 8'($urandom_range(0, 255));
            endcase
            ev_ready = ($urandom_range(0, 3) != 0);
            model_byte(b);
            send_byte(b, $urandom_range(0, 3));
        end
        ev_ready = 1'b1;
        wait_cyc(12);
        chk("rand_n", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("rand%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
        chk("rand_ovf", 32'(overflow), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
